// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampling UART receiver with CDC synchronizer, optional parity and error pulses
module uart_rx_oversampled #(
   parameter int INPUT_DATA_WIDTH           = 8,
   parameter int PARITY_ENABLED             = 1,
   parameter int PARITY_TYPE                = 0,
   parameter int CLOCKS_PER_BIT             = 8,
   parameter int NUMBER_OF_RX_SYNCHRONIZERS = 3
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        serial_in_i,
   output logic [INPUT_DATA_WIDTH-1:0] received_data_o,
   output logic                        data_is_valid_o,
   output logic                        parity_error_o,
   output logic                        framing_error_o,
   output logic                        rx_error_o,
   output logic                        rx_busy_o
);
   localparam int W  = INPUT_DATA_WIDTH;
   localparam int NS = NUMBER_OF_RX_SYNCHRONIZERS;
   localparam int CW = $clog2(CLOCKS_PER_BIT);
   localparam int BW = $clog2(W + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t         state_q, state_d;
   logic [NS-1:0]  sync_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [BW-1:0]  bit_q, bit_d;
   logic [W-1:0]   shift_q, shift_d, data_q, data_d;
   logic           perr_q, perr_d, armed_q, armed_d;
   logic           valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, re_q, re_d, busy_q, busy_d;
   logic           rx_s, mid, last;
   assign rx_s = sync_q[NS-1];
   assign mid  = cnt_q == CW'(CLOCKS_PER_BIT / 2 - 1);
   assign last = cnt_q == CW'(CLOCKS_PER_BIT - 1);
   assign received_data_o = data_q;
   assign data_is_valid_o = valid_q;
   assign parity_error_o  = pe_q;
   assign framing_error_o = fe_q;
   assign rx_error_o      = re_q;
   assign rx_busy_o       = busy_q;
   // shift the asynchronous line through the synchronizer chain; stages idle high
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) sync_q <= '1;
      else         sync_q <= {sync_q[NS-2:0], serial_in_i};
   // FSM, counters, shift register and registered outputs
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         armed_q <= 1'b0;
         valid_q <= 1'b0;
         pe_q    <= 1'b0;
         fe_q    <= 1'b0;
         re_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         armed_q <= armed_d;
         valid_q <= valid_d;
         pe_q    <= pe_d;
         fe_q    <= fe_d;
         re_q    <= re_d;
         busy_q  <= busy_d;
      end
   // next state: mid-bit sampling per state; the stop sample decides the frame outcome
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      perr_d  = perr_q;
      armed_d = armed_q;
      valid_d = 1'b0;
      pe_d    = 1'b0;
      fe_d    = 1'b0;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (rx_s) armed_d = 1'b1;
            else if (armed_q) begin
               state_d = START;
               bit_d   = '0;
               perr_d  = 1'b0;
            end
         end
         START: if (mid) begin
            cnt_d   = '0;
            state_d = rx_s ? IDLE : DATA;
         end
         DATA: if (last) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[W-1:1]};
            bit_d   = bit_q + BW'(1);
            if (bit_q == BW'(W - 1)) state_d = PARITY_ENABLED != 0 ? PARITY : STOP;
         end
         PARITY: if (last) begin
            cnt_d   = '0;
            perr_d  = rx_s != ((^shift_q) ^ 1'(PARITY_TYPE));
            state_d = STOP;
         end
         STOP: if (last) begin
            cnt_d   = '0;
            state_d = IDLE;
            armed_d = rx_s;
            valid_d = rx_s & ~perr_q;
            pe_d    = perr_q;
            fe_d    = ~rx_s;
            data_d  = valid_d ? shift_q : data_q;
         end
         default: state_d = IDLE;
      endcase
      re_d   = pe_d | fe_d;
      busy_d = state_d != IDLE;
   end
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed and random frames checked against a frame-level event model
module tb_uart_rx_oversampled;
   localparam int W   = 8;
   localparam int PE  = 1;
   localparam int PT  = 0;
   localparam int CPB = 8;
   localparam int NS  = 3;
   localparam int LAT = NS + CPB / 2 + (W + PE + 1) * CPB;
   typedef struct {
      int         cyc;
      bit         v;
      bit         pe;
      bit         fe;
      logic [W-1:0] d;
   } ev_t;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         serial = 1'b1;
   logic [W-1:0] received_data;
   logic         data_is_valid, parity_error, framing_error, rx_error, rx_busy;
   int           cyc = 0;
   int           total = 0;
   int           bad = 0;
   int           busy_cnt = 0;
   logic [W-1:0] last = '0;
   ev_t          exp_q[$];
   ev_t          got_q[$];
   uart_rx_oversampled #(
      .INPUT_DATA_WIDTH(W), .PARITY_ENABLED(PE), .PARITY_TYPE(PT),
      .CLOCKS_PER_BIT(CPB), .NUMBER_OF_RX_SYNCHRONIZERS(NS)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .serial_in_i(serial),
      .received_data_o(received_data), .data_is_valid_o(data_is_valid),
      .parity_error_o(parity_error), .framing_error_o(framing_error),
      .rx_error_o(rx_error), .rx_busy_o(rx_busy)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask
   always @(negedge clk) begin
      ev_t e;
      if (rx_busy) busy_cnt <= busy_cnt + 1;
      if (data_is_valid | parity_error | framing_error | rx_error) begin
         chk("valid_xor_err", {31'b0, data_is_valid & rx_error}, 0);
         chk("rx_err_or", {31'b0, rx_error}, {31'b0, parity_error | framing_error});
         e.cyc = cyc;
         e.v   = data_is_valid;
         e.pe  = parity_error;
         e.fe  = framing_error;
         e.d   = received_data;
         got_q.push_back(e);
      end
   end
   task automatic send_bit(input logic b);
      serial = b;
      repeat (CPB) @(negedge clk);
   endtask
   task automatic send_frame(input logic [W-1:0] d, input bit flip, input bit stopb, input int low_after, input int gap);
      ev_t  e;
      int   t0;
      logic par;
      t0  = cyc + 1;
      par = (^d) ^ 1'(PT) ^ flip;
      send_bit(1'b0);
      for (int i = 0; i < W; i++) send_bit(d[i]);
      if (PE != 0) send_bit(par);
      send_bit(stopb);
      serial = 1'b0;
      repeat (low_after) @(negedge clk);
      serial = 1'b1;
      repeat (gap) @(negedge clk);
      e.cyc = t0 + LAT;
      e.pe  = (PE != 0) && (par != ((^d) ^ 1'(PT)));
      e.fe  = !stopb;
      e.v   = stopb && !e.pe;
      if (e.v) last = d;
      e.d   = last;
      exp_q.push_back(e);
   endtask
   task automatic compare_events(input string tag);
      repeat (30) @(negedge clk);
      chk({tag, "_n_ev"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk({tag, "_cyc"}, got_q[i].cyc, exp_q[i].cyc);
         chk({tag, "_valid"}, {31'b0, got_q[i].v}, {31'b0, exp_q[i].v});
         chk({tag, "_perr"}, {31'b0, got_q[i].pe}, {31'b0, exp_q[i].pe});
         chk({tag, "_ferr"}, {31'b0, got_q[i].fe}, {31'b0, exp_q[i].fe});
         chk({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
      end
      chk({tag, "_hold"}, 32'(received_data), 32'(last));
      got_q.delete();
      exp_q.delete();
   endtask
   task automatic check_reset_outputs(input string tag);
      chk({tag, "_data"}, 32'(received_data), 0);
      chk({tag, "_pulses"}, {27'b0, data_is_valid, parity_error, framing_error, rx_error, rx_busy}, 0);
   endtask
   initial begin
      int b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      b0 = busy_cnt;
      send_frame(8'hA5, 0, 1, 0, 20);
      chk("busy_len", busy_cnt - b0, LAT - NS);
      compare_events("a5");
      send_frame(8'h3C, 1, 1, 0, 20);
      compare_events("par");
      b0 = busy_cnt;
      serial = 1'b0;
      repeat (3) @(negedge clk);
      serial = 1'b1;
      repeat (30) @(negedge clk);
      chk("glitch_busy", busy_cnt - b0, CPB / 2);
      send_frame(8'h01, 0, 1, 0, 20);
      compare_events("glitch");
      send_frame(8'h00, 0, 0, 40, 20);
      send_frame(8'h5A, 0, 1, 0, 20);
      compare_events("brk");
      send_frame(8'hFF, 0, 1, 0, 0);
      send_frame(8'h00, 0, 1, 0, 0);
      send_frame(8'h81, 0, 1, 0, 20);
      compare_events("b2b");
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      rst_n  = 1'b0;
      serial = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_rst");
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      last  = '0;
      repeat (20) @(negedge clk);
      send_frame(8'h7E, 0, 1, 0, 20);
      compare_events("rst");
      for (int n = 0; n < 25; n++) begin
         bit flip, stopb;
         flip  = $urandom_range(0, 3) == 0;
         stopb = $urandom_range(0, 7) != 0;
         send_frame(W'($urandom), flip, stopb, 0, stopb ? $urandom_range(0, 20) : CPB + $urandom_range(0, 10));
      end
      compare_events("rand");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
